pass_error_ctrl: RTL and testbench

PASS_ERROR_CTRL -- requirements
Module: pass_error_ctrl

---
 rtl/pass_error_ctrl_if.sv | 46 ++++
 rtl/pass_error_ctrl.sv | 129 ++++++++++++
 tb/tb_pass_error_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pass_error_ctrl_if.sv
// Control and result bundle between the pass-error controller, the coder,
// the error unit and downstream rate control.
interface pass_error_ctrl_if;
  logic        cb_start;
  logic        cb_abort;
  logic [3:0]  cfg_nbp;
  logic [3:0]  cfg_mul_factor;
  logic        bp_end;
  logic        coder_stall;
  logic [30:0] pass_error_sp;
  logic [30:0] pass_error_mrp;
  logic [30:0] pass_error_cp;
  logic        dist_rdy;

  logic        pass_error_start;
  logic        clear0;
  logic        stop_d;
  logic        stall_vld;
  logic [3:0]  count_bp;
  logic [3:0]  mul_factor_error;
  logic        dist_vld;
  logic [30:0] dist_sp;
  logic [30:0] dist_mrp;
  logic [30:0] dist_cp;
  logic [3:0]  dist_bp;
  logic        cb_done;
  logic        proto_err;

  // Controller side
  modport slave (
    input  cb_start, cb_abort, cfg_nbp, cfg_mul_factor, bp_end, coder_stall,
           pass_error_sp, pass_error_mrp, pass_error_cp, dist_rdy,
    output pass_error_start, clear0, stop_d, stall_vld, count_bp,
           mul_factor_error, dist_vld, dist_sp, dist_mrp, dist_cp, dist_bp,
           cb_done, proto_err
  );

  // Stimulus / environment side
  modport master (
    output cb_start, cb_abort, cfg_nbp, cfg_mul_factor, bp_end, coder_stall,
           pass_error_sp, pass_error_mrp, pass_error_cp, dist_rdy,
    input  pass_error_start, clear0, stop_d, stall_vld, count_bp,
           mul_factor_error, dist_vld, dist_sp, dist_mrp, dist_cp, dist_bp,
           cb_done, proto_err
  );
endinterface

// File: rtl/pass_error_ctrl.sv
// Pass-error controller: sequences the error unit bitplane by bitplane
// (MSB plane first), waits out the error-unit drain latency, captures the
// accumulated pass errors and hands them downstream with a valid/ready.
module pass_error_ctrl #(
  parameter int unsigned DRAIN_LAT = 4
) (
  input  logic              clk_pass_pre,
  input  logic              rst_syn,
  pass_error_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_OUT   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [3:0] LP_DRAIN = 4'(DRAIN_LAT);

  logic [2:0]  r_state;
  logic [3:0]  r_drain_cnt;
  logic [3:0]  r_count_bp;
  logic [3:0]  r_mul_factor;
  logic        r_stop_d;
  logic        r_abort_clr;
  logic        r_proto_err;
  logic [30:0] r_dist_sp;
  logic [30:0] r_dist_mrp;
  logic [30:0] r_dist_cp;
  logic [3:0]  r_dist_bp;

  logic w_abort;
  logic w_handshake;

  // Abort only matters once a code-block is in flight; it outranks every
  // other event, so the output handshake is suppressed in the same cycle.
  assign w_abort     = bus.cb_abort && (r_state != S_IDLE);
  assign w_handshake = (r_state == S_OUT) && bus.dist_rdy && !w_abort;

  // Main sequencing FSM with drain counter, bitplane counter and result capture
  always_ff @(posedge clk_pass_pre) begin
    if (rst_syn) begin
      r_state      <= S_IDLE;
      r_drain_cnt  <= '0;
      r_count_bp   <= '0;
      r_mul_factor <= '0;
      r_stop_d     <= 1'b0;
      r_abort_clr  <= 1'b0;
      r_proto_err  <= 1'b0;
      r_dist_sp    <= '0;
      r_dist_mrp   <= '0;
      r_dist_cp    <= '0;
      r_dist_bp    <= '0;
    end else begin
      r_stop_d    <= 1'b0;
      r_abort_clr <= 1'b0;
      if (w_abort) begin
        r_state     <= S_IDLE;
        r_abort_clr <= 1'b1;
      end else begin
        if (bus.bp_end && (r_state != S_RUN))
          r_proto_err <= 1'b1;
        case (r_state)
          S_IDLE: begin
            if (bus.cb_start) begin
              if (bus.cfg_nbp != 4'd0) begin
                r_mul_factor <= bus.cfg_mul_factor;
                r_count_bp   <= bus.cfg_nbp - 4'd1;
                r_state      <= S_START;
              end else begin
                r_proto_err  <= 1'b1;
              end
            end
          end
          S_START: r_state <= S_RUN;
          S_RUN: begin
            if (bus.bp_end) begin
              r_stop_d    <= 1'b1;
              r_drain_cnt <= LP_DRAIN;
              r_state     <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (r_drain_cnt == 4'd0) begin
              r_dist_sp  <= bus.pass_error_sp;
              r_dist_mrp <= bus.pass_error_mrp;
              r_dist_cp  <= bus.pass_error_cp;
              r_dist_bp  <= r_count_bp;
              r_state    <= S_OUT;
            end else begin
              r_drain_cnt <= r_drain_cnt - 4'd1;
            end
          end
          S_OUT: begin
            if (w_handshake) begin
              if (r_count_bp == 4'd0) begin
                r_state <= S_DONE;
              end else begin
                r_count_bp <= r_count_bp - 4'd1;
                r_state    <= S_START;
              end
            end
          end
          S_DONE:  r_state <= S_IDLE;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  // Output decode; strobes are masked during reset so no clear leaks out
  always_comb begin
    bus.pass_error_start = !rst_syn && (r_state == S_START);
    bus.clear0           = !rst_syn && ((r_state == S_START) || r_abort_clr);
    bus.stop_d           = r_stop_d;
    bus.stall_vld        = (r_state == S_RUN) && bus.coder_stall;
    bus.count_bp         = r_count_bp;
    bus.mul_factor_error = r_mul_factor;
    bus.dist_vld         = (r_state == S_OUT) && !bus.cb_abort;
    bus.dist_sp          = r_dist_sp;
    bus.dist_mrp         = r_dist_mrp;
    bus.dist_cp          = r_dist_cp;
    bus.dist_bp          = r_dist_bp;
    bus.cb_done          = (r_state == S_DONE) && !bus.cb_abort;
    bus.proto_err        = r_proto_err;
  end

endmodule

// File: tb/tb_pass_error_ctrl.sv
// Bench for pass_error_ctrl: cycle vector table for a one-plane code-block
// and protocol errors, then directed multi-cycle sequences.
module tb_pass_error_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  pass_error_ctrl_if bus ();

  pass_error_ctrl #(.DRAIN_LAT(4)) dut (
    .clk_pass_pre (clk),
    .rst_syn      (rst),
    .bus          (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic       abort;
    logic       bpe;
    logic       stall;
    logic       rdy;
    logic [3:0] nbp;
    logic [6:0] exp;   // {pe_start, clear0, stop_d, stall_vld, dist_vld, cb_done, proto_err}
    logic [3:0] ecbp;
  } vec_t;

  vec_t vecs [16];

  function automatic vec_t mk(input logic s, input logic a, input logic b,
                              input logic st, input logic r, input logic [3:0] n,
                              input logic [6:0] e, input logic [3:0] c);
    vec_t v;
    v.start = s; v.abort = a; v.bpe = b; v.stall = st; v.rdy = r;
    v.nbp = n; v.exp = e; v.ecbp = c;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.cb_start = 1'b0; bus.cb_abort = 1'b0; bus.bp_end = 1'b0;
    bus.coder_stall = 1'b0; bus.dist_rdy = 1'b0;
    bus.cfg_nbp = 4'd0; bus.cfg_mul_factor = 4'd0;
    step();
    step();
    rst = 1'b0;
  endtask

  function automatic logic [6:0] outs();
    return {bus.pass_error_start, bus.clear0, bus.stop_d, bus.stall_vld,
            bus.dist_vld, bus.cb_done, bus.proto_err};
  endfunction

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int since, nstop, nvld, stop_cyc, starts, clrs, dones, mfbad, nv, nd;
    logic [30:0] held_sp, held_cp;

    bus.pass_error_sp = 31'h0123_4567;
    bus.pass_error_mrp = 31'h0222_2222;
    bus.pass_error_cp = 31'h0333_3333;
    do_reset();

    // Reset state
    @(negedge clk);
    check("reset_outs", {57'd0, outs()}, 64'd0);
    check("reset_regs", {bus.count_bp, bus.mul_factor_error, bus.dist_bp, bus.dist_sp},
          64'd0);
    step();

    // One-plane code-block, ignored cb_start in RUN, protocol errors in IDLE
    vecs[0]  = mk(0,0,0,0,0,4'd1, 7'b0000000, 4'd0);
    vecs[1]  = mk(1,0,0,0,0,4'd1, 7'b0000000, 4'd0);
    vecs[2]  = mk(0,0,0,0,0,4'd1, 7'b1100000, 4'd0);
    vecs[3]  = mk(0,0,0,1,0,4'd1, 7'b0001000, 4'd0);
    vecs[4]  = mk(1,0,1,0,0,4'd1, 7'b0000000, 4'd0);
    vecs[5]  = mk(0,0,0,1,0,4'd1, 7'b0010000, 4'd0);
    vecs[6]  = mk(0,0,0,1,1,4'd1, 7'b0000000, 4'd0);
    vecs[7]  = mk(0,0,0,0,1,4'd1, 7'b0000000, 4'd0);
    vecs[8]  = mk(0,0,0,0,0,4'd1, 7'b0000000, 4'd0);
    vecs[9]  = mk(0,0,0,0,0,4'd1, 7'b0000000, 4'd0);
    vecs[10] = mk(0,0,0,0,0,4'd1, 7'b0000100, 4'd0);
    vecs[11] = mk(0,0,0,0,1,4'd1, 7'b0000100, 4'd0);
    vecs[12] = mk(0,0,0,0,0,4'd1, 7'b0000010, 4'd0);
    vecs[13] = mk(0,0,1,0,0,4'd1, 7'b0000000, 4'd0);
    vecs[14] = mk(1,0,0,0,0,4'd0, 7'b0000001, 4'd0);
    vecs[15] = mk(0,0,0,0,0,4'd0, 7'b0000001, 4'd0);
    bus.cfg_mul_factor = 4'd7;
    for (int i = 0; i < 16; i++) begin
      bus.cb_start = vecs[i].start; bus.cb_abort = vecs[i].abort;
      bus.bp_end = vecs[i].bpe; bus.coder_stall = vecs[i].stall;
      bus.dist_rdy = vecs[i].rdy; bus.cfg_nbp = vecs[i].nbp;
      @(negedge clk);
      check($sformatf("vec%0d", i), {53'd0, bus.count_bp, outs()},
            {53'd0, vecs[i].ecbp, vecs[i].exp});
      step();
    end
    bus.cb_start = 1'b0; bus.bp_end = 1'b0; bus.coder_stall = 1'b0;
    check("tbl_dist_sp", {33'd0, bus.dist_sp}, 64'h0123_4567);
    check("tbl_dist_cp", {33'd0, bus.dist_cp}, 64'h0333_3333);
    check("tbl_mul", {60'd0, bus.mul_factor_error}, 64'd7);

    // Three-plane code-block, bp_end 20 cycles after each START
    do_reset();
    bus.cfg_nbp = 4'd3; bus.cfg_mul_factor = 4'd5; bus.dist_rdy = 1'b1;
    bus.cb_start = 1'b1;
    step();
    bus.cb_start = 1'b0;
    since = -1; nstop = 0; nvld = 0; stop_cyc = -1;
    starts = 0; clrs = 0; dones = 0; mfbad = 0;
    for (int c = 0; c < 120; c++) begin
      bus.bp_end = (since == 19);
      if (since == 19) since = -1;
      bus.pass_error_sp = 31'(32'h1000 + 32'(nstop));
      bus.pass_error_cp = 31'(32'h3000 + 32'(nstop));
      @(negedge clk);
      if (bus.pass_error_start) begin
        starts++;
        since = 0;
      end else if (since >= 0) begin
        since++;
      end
      if (bus.clear0) clrs++;
      if (bus.stop_d) begin
        nstop++;
        stop_cyc = c;
      end
      if (bus.dist_vld) begin
        check($sformatf("run_lat%0d", nvld), 64'(c - stop_cyc), 64'd5);
        check($sformatf("run_bp%0d", nvld), {60'd0, bus.dist_bp}, 64'(2 - nvld));
        check($sformatf("run_sp%0d", nvld), {33'd0, bus.dist_sp}, 64'(32'h1000 + 32'(nstop)));
        check($sformatf("run_cp%0d", nvld), {33'd0, bus.dist_cp}, 64'(32'h3000 + 32'(nstop)));
        nvld++;
      end
      if (bus.mul_factor_error != 4'd5) mfbad++;
      if (bus.cb_done) dones++;
      step();
    end
    bus.bp_end = 1'b0;
    check("run_starts", 64'(starts), 64'd3);
    check("run_clear0", 64'(clrs), 64'd3);
    check("run_nvld", 64'(nvld), 64'd3);
    check("run_done", 64'(dones), 64'd1);
    check("run_mul_bad", 64'(mfbad), 64'd0);
    check("run_perr", {63'd0, bus.proto_err}, 64'd0);

    // Stall mirroring, bp_end under stall, backpressure in OUT
    do_reset();
    bus.cfg_nbp = 4'd2; bus.cfg_mul_factor = 4'd3;
    bus.pass_error_sp = 31'h0AAA_5555; bus.pass_error_cp = 31'h0555_AAAA;
    bus.cb_start = 1'b1;
    step();
    bus.cb_start = 1'b0;
    step();
    for (int k = 0; k < 6; k++) begin
      bus.coder_stall = (k % 2 == 1);
      @(negedge clk);
      check($sformatf("stall_mirror%0d", k), {63'd0, bus.stall_vld}, {63'd0, bus.coder_stall});
      step();
    end
    bus.coder_stall = 1'b1; bus.bp_end = 1'b1;
    step();
    bus.bp_end = 1'b0;
    @(negedge clk);
    check("stop_under_stall", {63'd0, bus.stop_d}, 64'd1);
    check("stall_vld_drain", {63'd0, bus.stall_vld}, 64'd0);
    step();
    for (int k = 0; k < 20 && !bus.dist_vld; k++) step();
    check("bp_out_reached", {63'd0, bus.dist_vld}, 64'd1);
    check("bp_dist_bp", {60'd0, bus.dist_bp}, 64'd1);
    check("stall_vld_out", {63'd0, bus.stall_vld}, 64'd0);
    held_sp = 31'h0AAA_5555; held_cp = 31'h0555_AAAA;
    nv = 0;
    for (int k = 0; k < 10; k++) begin
      bus.pass_error_sp = 31'($urandom);
      bus.pass_error_cp = 31'($urandom);
      @(negedge clk);
      if (bus.dist_vld) nv++;
      check($sformatf("bp_sp%0d", k), {33'd0, bus.dist_sp}, {33'd0, held_sp});
      check($sformatf("bp_cp%0d", k), {33'd0, bus.dist_cp}, {33'd0, held_cp});
      check($sformatf("bp_nostart%0d", k), {63'd0, bus.pass_error_start}, 64'd0);
      step();
    end
    check("bp_vld_held", 64'(nv), 64'd10);
    bus.dist_rdy = 1'b1;
    step();
    bus.dist_rdy = 1'b0;
    @(negedge clk);
    check("bp_start_after_hs", {63'd0, bus.pass_error_start}, 64'd1);
    check("bp_count_after_hs", {60'd0, bus.count_bp}, 64'd0);
    bus.coder_stall = 1'b0;

    // Abort in DRAIN with count_bp=1
    do_reset();
    bus.cfg_nbp = 4'd2; bus.cfg_mul_factor = 4'd4; bus.dist_rdy = 1'b1;
    bus.cb_start = 1'b1;
    step();
    bus.cb_start = 1'b0;
    step();
    bus.bp_end = 1'b1;
    step();
    bus.bp_end = 1'b0;
    @(negedge clk);
    check("ab_count_drain", {60'd0, bus.count_bp}, 64'd1);
    step();
    bus.cb_abort = 1'b1;
    step();
    bus.cb_abort = 1'b0;
    @(negedge clk);
    check("ab_clear0", {63'd0, bus.clear0}, 64'd1);
    check("ab_nostart", {63'd0, bus.pass_error_start}, 64'd0);
    step();
    @(negedge clk);
    check("ab_clear0_off", {63'd0, bus.clear0}, 64'd0);
    nv = 0; nd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.dist_vld) nv++;
      if (bus.cb_done) nd++;
      step();
    end
    check("ab_no_vld", 64'(nv), 64'd0);
    check("ab_no_done", 64'(nd), 64'd0);
    bus.cfg_nbp = 4'd4; bus.cb_start = 1'b1;
    step();
    bus.cb_start = 1'b0;
    @(negedge clk);
    check("ab_restart", {63'd0, bus.pass_error_start}, 64'd1);
    check("ab_restart_cnt", {60'd0, bus.count_bp}, 64'd3);
    check("ab_perr", {63'd0, bus.proto_err}, 64'd0);

    // Reset pulsed in OUT, then immediate restart
    do_reset();
    bus.bp_end = 1'b1;
    step();
    bus.bp_end = 1'b0;
    @(negedge clk);
    check("rs_perr_set", {63'd0, bus.proto_err}, 64'd1);
    step();
    bus.cfg_nbp = 4'd1; bus.cfg_mul_factor = 4'd9; bus.dist_rdy = 1'b0;
    bus.pass_error_sp = 31'h0777_0001;
    bus.cb_start = 1'b1;
    step();
    bus.cb_start = 1'b0;
    step();
    bus.bp_end = 1'b1;
    step();
    bus.bp_end = 1'b0;
    for (int k = 0; k < 20 && !bus.dist_vld; k++) step();
    check("rs_out_reached", {63'd0, bus.dist_vld}, 64'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    bus.cfg_nbp = 4'd2; bus.cb_start = 1'b1;
    @(negedge clk);
    check("rs_outs", {57'd0, outs()}, 64'd0);
    check("rs_regs", {bus.count_bp, bus.mul_factor_error, bus.dist_bp, bus.dist_sp}, 64'd0);
    step();
    bus.cb_start = 1'b0;
    @(negedge clk);
    check("rs_restart", {63'd0, bus.pass_error_start}, 64'd1);
    check("rs_restart_cnt", {60'd0, bus.count_bp}, 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
